rege_pipe: RTL and testbench
============================

// Module: rege_pipe
// PURPOSE
//  Decode->execute pipeline register ("regE") for the rv64 two-stage-plus pipeline.
//  Captures the decode bus and the commit-trace bus with a valid/ready handshake.
//  A 2-entry skid buffer (main + skid) decouples the two stages.
//  Flush input kills in-flight entries on a branch redirect.
// PARAMETERS
//  BUS_W   256  width of decode_i_bus_info / regE_o_bus_info
//  CMT_W   161  width of commit-trace bus (pc, inst, next-pc, valid tag)
//  CNT_W   32   perf counter width (only with REGE_PERF_CNT_EN)
// PORTS
//  clk                  in   1      clock, all state on rising edge
//  rst                  in   1      synchronous reset, active-high
//  decode_i_valid       in   1      upstream entry valid
//  decode_o_ready       out  1      this block can accept an entry
//  decode_i_bus_info    in   BUS_W  decoded-op payload
//  decode_i_commit_info in   CMT_W  commit-trace payload
//  regE_o_valid         out  1      entry presented to execute
//  execute_i_ready      in   1      execute consumes the entry this cycle
//  regE_o_bus_info      out  BUS_W  payload to execute
//  regE_o_commit_info   out  CMT_W  commit trace to execute
//  flush_i              in   1      redirect: kill all held entries
//  perf_stall_cnt       out  CNT_W  (REGE_PERF_CNT_EN only) stall cycles
//  perf_kill_cnt        out  CNT_W  (REGE_PERF_CNT_EN only) entries killed by flush
// BEHAVIOUR
//  Reset: main_vld=0, skid_vld=0, regE_o_valid=0, all payload regs=0, counters=0.
//  - decode_o_ready = ~skid_vld & ~rst; derived from registers only, no comb path from execute_i_ready.
//  - regE_o_valid = main_vld; outputs driven directly from main regs.
//  - in_fire  = decode_i_valid & decode_o_ready.
//  - out_fire = regE_o_valid & execute_i_ready.
//  Latency: entry accepted in cycle N is presented at cycle N+1 if main is free or drains at N.
//  Next-state rules (flush_i=0):
//  - main empty (or out_fire), skid empty, in_fire: input -> main.
//  - main empty (or out_fire), skid full: skid -> main, skid_vld=0; in_fire impossible (ready=0).
//  - main full and no out_fire, in_fire: input -> skid, skid_vld=1.
//  - out_fire with no refill: main_vld=0.
//  - Payload regs load only when their entry is written; they hold otherwise.
//  Ordering is strict FIFO: main always holds the older entry. No entry is duplicated or lost.
//  Flush (flush_i=1): next main_vld=0, skid_vld=0.
//  - Flush beats in_fire and out_fire in the same cycle; the input is dropped.
//  - The entry in main may still be consumed (out_fire) in the flush cycle.
//  - Payload regs are not cleared.
//  Back-pressure boundary: with execute_i_ready=0, accepts exactly 2 entries, then decode_o_ready=0.
//  - decode_o_ready returns to 1 the cycle after the first out_fire.
//  Reset mid-operation: both entries discarded; decode_o_ready=0 during rst, 1 the cycle after.
// CONFIGURATION
//  REGE_PERF_CNT_EN defined:
//  - perf_stall_cnt += 1 each cycle with regE_o_valid & ~execute_i_ready.
//  - perf_kill_cnt += main_vld + skid_vld - out_fire on each flush cycle.
//  - Both counters wrap modulo 2^CNT_W and are cleared by rst.
//  REGE_PERF_CNT_EN undefined: the perf ports and counter logic do not exist; the port list ends at flush_i.
// TESTING
//  1 Reset: rst 3 cycles -> regE_o_valid=0, payload=0, decode_o_ready=0 in rst, 1 after.
//  2 Streaming: valid=1, ready=1, bus=1,2,3... -> regE_o_bus_info 1,2,3 one cycle later; no bubbles.
//  3 Skid: ready=0 after entry A; feed B, C -> A held, B in skid, decode_o_ready=0, C not taken.
//    Then ready=1 -> A, B, C emerge in order.
//  4 Flush with 2 held: flush_i=1, in_fire attempted with D -> next cycle valid=0, D never emerges.
//    Next entry E passes normally.
//  5 Flush with out_fire same cycle -> A consumed once, B killed; perf_kill_cnt+=1 (PERF_EN).
//  6 PERF_EN: 10 cycles of valid & ~ready -> perf_stall_cnt=10; preset near 2^CNT_W-1 wraps to 0.

Source files
------------

// File: rtl/rege_pipe.sv
// Decode->execute pipeline register with a 2-entry (main + skid) buffer.
// Optional perf counters: define REGE_PERF_CNT_EN to add perf_stall_cnt / perf_kill_cnt.
module rege_pipe #(
   parameter int unsigned BUS_W = 256,
   parameter int unsigned CMT_W = 161
`ifdef REGE_PERF_CNT_EN
   ,
   parameter int unsigned CNT_W = 32
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             decode_i_valid,
   output logic             decode_o_ready,
   input  logic [BUS_W-1:0] decode_i_bus_info,
   input  logic [CMT_W-1:0] decode_i_commit_info,
   output logic             regE_o_valid,
   input  logic             execute_i_ready,
   output logic [BUS_W-1:0] regE_o_bus_info,
   output logic [CMT_W-1:0] regE_o_commit_info,
   input  logic             flush_i
`ifdef REGE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] perf_stall_cnt,
   output logic [CNT_W-1:0] perf_kill_cnt
`endif
);

   logic             main_vld_q, main_vld_d;
   logic             skid_vld_q, skid_vld_d;
   logic [BUS_W-1:0] main_bus_q, main_bus_d;
   logic [CMT_W-1:0] main_cmt_q, main_cmt_d;
   logic [BUS_W-1:0] skid_bus_q, skid_bus_d;
   logic [CMT_W-1:0] skid_cmt_q, skid_cmt_d;
   logic             in_fire;
   logic             out_fire;
   logic             main_free;

   // Handshake: ready depends only on the skid register, never on execute_i_ready
   assign decode_o_ready     = ~skid_vld_q & ~rst;
   assign regE_o_valid       = main_vld_q;
   assign regE_o_bus_info    = main_bus_q;
   assign regE_o_commit_info = main_cmt_q;
   assign in_fire            = decode_i_valid & decode_o_ready;
   assign out_fire           = main_vld_q & execute_i_ready;
   assign main_free          = ~main_vld_q | out_fire;

   // Next-state for the two entries; main always holds the older entry
   always_comb begin
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      main_bus_d = main_bus_q;
      main_cmt_d = main_cmt_q;
      skid_bus_d = skid_bus_q;
      skid_cmt_d = skid_cmt_q;
      if (flush_i) begin
         // Redirect kills everything held; the input is dropped, payloads keep stale data
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (main_free) begin
         if (skid_vld_q) begin
            main_vld_d = 1'b1;
            main_bus_d = skid_bus_q;
            main_cmt_d = skid_cmt_q;
            skid_vld_d = 1'b0;
         end else if (in_fire) begin
            main_vld_d = 1'b1;
            main_bus_d = decode_i_bus_info;
            main_cmt_d = decode_i_commit_info;
         end else begin
            main_vld_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_vld_d = 1'b1;
         skid_bus_d = decode_i_bus_info;
         skid_cmt_d = decode_i_commit_info;
      end
   end

   // Entry state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         main_bus_q <= '0;
         main_cmt_q <= '0;
         skid_bus_q <= '0;
         skid_cmt_q <= '0;
      end else begin
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         main_bus_q <= main_bus_d;
         main_cmt_q <= main_cmt_d;
         skid_bus_q <= skid_bus_d;
         skid_cmt_q <= skid_cmt_d;
      end
   end

`ifdef REGE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] kill_cnt_q,  kill_cnt_d;

   // Stall cycles and flush-killed entries; both wrap naturally
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      kill_cnt_d  = kill_cnt_q;
      if (main_vld_q & ~execute_i_ready) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_i) begin
         kill_cnt_d = kill_cnt_q + CNT_W'(main_vld_q) + CNT_W'(skid_vld_q) - CNT_W'(out_fire);
      end
   end

   // Perf counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         kill_cnt_q  <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         kill_cnt_q  <= kill_cnt_d;
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_kill_cnt  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_rege_pipe.sv
// Directed bench for rege_pipe; perf checks compile in with REGE_PERF_CNT_EN.
module tb_rege_pipe;

   localparam int unsigned BUS_W = 256;
   localparam int unsigned CMT_W = 161;
`ifdef REGE_PERF_CNT_EN
   localparam int unsigned CNT_W = 4;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             decode_i_valid;
   logic             decode_o_ready;
   logic [BUS_W-1:0] decode_i_bus_info;
   logic [CMT_W-1:0] decode_i_commit_info;
   logic             regE_o_valid;
   logic             execute_i_ready;
   logic [BUS_W-1:0] regE_o_bus_info;
   logic [CMT_W-1:0] regE_o_commit_info;
   logic             flush_i;
`ifdef REGE_PERF_CNT_EN
   logic [CNT_W-1:0] perf_stall_cnt;
   logic [CNT_W-1:0] perf_kill_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rege_pipe #(
      .BUS_W(BUS_W),
      .CMT_W(CMT_W)
`ifdef REGE_PERF_CNT_EN
      ,
      .CNT_W(CNT_W)
`endif
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .decode_i_valid      (decode_i_valid),
      .decode_o_ready      (decode_o_ready),
      .decode_i_bus_info   (decode_i_bus_info),
      .decode_i_commit_info(decode_i_commit_info),
      .regE_o_valid        (regE_o_valid),
      .execute_i_ready     (execute_i_ready),
      .regE_o_bus_info     (regE_o_bus_info),
      .regE_o_commit_info  (regE_o_commit_info),
      .flush_i             (flush_i)
`ifdef REGE_PERF_CNT_EN
      ,
      .perf_stall_cnt      (perf_stall_cnt),
      .perf_kill_cnt       (perf_kill_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an upstream entry tagged k (commit payload = k + 1000)
   task automatic drive(input int k);
      decode_i_valid       = 1'b1;
      decode_i_bus_info    = BUS_W'(k);
      decode_i_commit_info = CMT_W'(k + 1000);
   endtask

   // Check the presented entry carries tag k
   task automatic expect_entry(input string tag, input int k);
      chk({tag, "_valid"}, 256'(regE_o_valid), 256'(1));
      chk({tag, "_bus"}, 256'(regE_o_bus_info), 256'(k));
      chk({tag, "_cmt"}, 256'(regE_o_commit_info), 256'(k + 1000));
   endtask

   initial begin
      rst                  = 1'b1;
      decode_i_valid       = 1'b0;
      decode_i_bus_info    = '0;
      decode_i_commit_info = '0;
      execute_i_ready      = 1'b0;
      flush_i              = 1'b0;

      // 1 Reset for 3 cycles
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_ready", 256'(decode_o_ready), 256'(0));
         chk("rst_valid", 256'(regE_o_valid), 256'(0));
      end
      chk("rst_bus", 256'(regE_o_bus_info), 256'(0));
      chk("rst_cmt", 256'(regE_o_commit_info), 256'(0));
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 256'(decode_o_ready), 256'(1));

      // 2 Streaming, no bubbles
      execute_i_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         drive(k);
         step();
         expect_entry("stream", k);
         chk("stream_ready", 256'(decode_o_ready), 256'(1));
      end
      decode_i_valid = 1'b0;
      step();
      chk("stream_drain", 256'(regE_o_valid), 256'(0));

      // 3 Skid: A held, B in skid, C refused, then A,B,C in order
      execute_i_ready = 1'b0;
      drive(10);
      step();
      expect_entry("skid_a", 10);
      drive(11);
      step();
      expect_entry("skid_a_held", 10);
      chk("skid_full_ready", 256'(decode_o_ready), 256'(0));
      drive(12);
      step();
      expect_entry("skid_c_refused", 10);
      chk("skid_still_full", 256'(decode_o_ready), 256'(0));
      execute_i_ready = 1'b1;
      step();
      expect_entry("skid_b", 11);
      chk("skid_ready_back", 256'(decode_o_ready), 256'(1));
      step();
      expect_entry("skid_c", 12);
      decode_i_valid = 1'b0;
      step();
      chk("skid_drain", 256'(regE_o_valid), 256'(0));

      // 4 Flush with 2 held, then D dropped while an in_fire is possible
      execute_i_ready = 1'b0;
      drive(20);
      step();
      drive(21);
      step();
      chk("fl2_full", 256'(decode_o_ready), 256'(0));
      drive(22);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      decode_i_valid = 1'b0;
      chk("fl2_valid", 256'(regE_o_valid), 256'(0));
      chk("fl2_ready", 256'(decode_o_ready), 256'(1));
      drive(23);
      step();
      expect_entry("fl_e", 23);
      drive(24);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      decode_i_valid = 1'b0;
      chk("fl_drop_d", 256'(regE_o_valid), 256'(0));
      step();
      chk("fl_drop_d2", 256'(regE_o_valid), 256'(0));
      execute_i_ready = 1'b1;
      drive(25);
      step();
      expect_entry("fl_next", 25);
      decode_i_valid = 1'b0;
      step();
      chk("fl_next_drain", 256'(regE_o_valid), 256'(0));

      // 5 Flush together with out_fire: A consumed, B killed
      execute_i_ready = 1'b0;
      drive(30);
      step();
      drive(31);
      step();
      decode_i_valid = 1'b0;
      expect_entry("flo_a", 30);
      execute_i_ready = 1'b1;
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      chk("flo_valid", 256'(regE_o_valid), 256'(0));
      step();
      chk("flo_b_gone", 256'(regE_o_valid), 256'(0));

      // Reset mid-operation with both entries held
      execute_i_ready = 1'b0;
      drive(40);
      step();
      drive(41);
      step();
      decode_i_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", 256'(decode_o_ready), 256'(0));
      step();
      chk("mid_rst_valid", 256'(regE_o_valid), 256'(0));
      rst = 1'b0;
      #1;
      chk("mid_rst_ready_after", 256'(decode_o_ready), 256'(1));
      step();
      chk("mid_rst_empty", 256'(regE_o_valid), 256'(0));

`ifdef REGE_PERF_CNT_EN
      // 6 Perf counters (CNT_W=4 so 16 stalls wrap to 0)
      rst = 1'b1;
      step();
      rst = 1'b0;
      drive(50);
      step();
      decode_i_valid = 1'b0;
      chk("perf_stall_0", 256'(perf_stall_cnt), 256'(0));
      for (int i = 0; i < 10; i++) step();
      chk("perf_stall_10", 256'(perf_stall_cnt), 256'(10));
      for (int i = 0; i < 6; i++) step();
      chk("perf_stall_wrap", 256'(perf_stall_cnt), 256'(0));
      drive(51);
      step();
      decode_i_valid = 1'b0;
      chk("perf_stall_1", 256'(perf_stall_cnt), 256'(1));
      execute_i_ready = 1'b1;
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      chk("perf_kill_1", 256'(perf_kill_cnt), 256'(1));
      chk("perf_stall_hold", 256'(perf_stall_cnt), 256'(1));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
